// File: rtl/fetch_ctrl_pkg.sv
// Shared types and constants for the instruction fetch sequencer.
package fetch_ctrl_pkg;

  localparam int unsigned ADDR_W_DEFAULT  = 64;
  localparam int unsigned INSTR_W_DEFAULT = 32;
  localparam logic [63:0] RESET_PC_DEFAULT = 64'h8000_0000;

  typedef enum logic [1:0] {
    StIdle,
    StFetch,
    StDrain
  } fetch_state_t;

  // Output slot contents as seen by decode.
  typedef struct packed {
    logic        valid;
    logic [63:0] pc;
    logic [31:0] raw;
    logic        misalign;
  } fetch_slot_t;

  typedef fetch_slot_t data_fetch_t;

  // Instructions are 4-byte aligned; any low bit set is a fault.
  function automatic logic is_misaligned(input logic [1:0] pc_lsb);
    return pc_lsb != 2'b00;
  endfunction

endpackage

// File: rtl/fetch_ctrl_slot.sv
// Output instruction register: clear > load > fire-clear > hold.
module fetch_ctrl_slot #(
  parameter int unsigned ADDR_W  = 64,
  parameter int unsigned INSTR_W = 32
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               clear_i,
  input  logic               load_i,
  input  logic [ADDR_W-1:0]  load_pc_i,
  input  logic [INSTR_W-1:0] load_raw_i,
  input  logic               load_misalign_i,
  input  logic               stall_i,
  output logic               fire_o,
  output logic               valid_o,
  output logic [ADDR_W-1:0]  pc_o,
  output logic [INSTR_W-1:0] raw_o,
  output logic               misalign_o
);

  logic               valid_q, valid_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [INSTR_W-1:0] raw_q, raw_d;
  logic               misalign_q, misalign_d;
  logic               fire;

  // Next slot contents by priority; a consumed slot is zeroed.
  always_comb begin
    fire       = valid_q & ~stall_i;
    valid_d    = valid_q;
    pc_d       = pc_q;
    raw_d      = raw_q;
    misalign_d = misalign_q;
    if (clear_i || (!load_i && fire)) begin
      valid_d    = 1'b0;
      pc_d       = '0;
      raw_d      = '0;
      misalign_d = 1'b0;
    end else if (load_i) begin
      valid_d    = 1'b1;
      pc_d       = load_pc_i;
      raw_d      = load_raw_i;
      misalign_d = load_misalign_i;
    end
  end

  // Slot register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q    <= 1'b0;
      pc_q       <= '0;
      raw_q      <= '0;
      misalign_q <= 1'b0;
    end else begin
      valid_q    <= valid_d;
      pc_q       <= pc_d;
      raw_q      <= raw_d;
      misalign_q <= misalign_d;
    end
  end

  assign fire_o     = fire;
  assign valid_o    = valid_q;
  assign pc_o       = pc_q;
  assign raw_o      = raw_q;
  assign misalign_o = misalign_q;

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch-stage sequencer: owns the PC, runs the ibus handshake and feeds decode.
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W   = ADDR_W_DEFAULT,
  parameter int unsigned INSTR_W  = INSTR_W_DEFAULT,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEFAULT)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  input  logic               stall,
  output logic               ireq_valid,
  output logic [ADDR_W-1:0]  ireq_addr,
  input  logic               iresp_data_ok,
  input  logic [INSTR_W-1:0] iresp_data,
  output logic               inst_valid,
  output logic [ADDR_W-1:0]  inst_pc,
  output logic [INSTR_W-1:0] inst_raw,
  output logic               inst_misalign
);

  fetch_state_t       state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [ADDR_W-1:0]  req_addr_q, req_addr_d;

  logic               slot_clear, slot_load, slot_fire;
  logic [ADDR_W-1:0]  slot_load_pc;
  logic [INSTR_W-1:0] slot_load_raw;
  logic               slot_load_misalign;
  logic               can_launch;

  // Next-state, PC and slot control; redirect wins in every state.
  always_comb begin
    state_d            = state_q;
    pc_d               = pc_q;
    req_addr_d         = req_addr_q;
    slot_clear         = 1'b0;
    slot_load          = 1'b0;
    slot_load_pc       = pc_q;
    slot_load_raw      = '0;
    slot_load_misalign = 1'b0;
    can_launch         = ~inst_valid | slot_fire;

    unique case (state_q)
      StIdle: begin
        if (redirect_valid) begin
          pc_d       = redirect_pc;
          slot_clear = 1'b1;
        end else if (can_launch) begin
          if (is_misaligned(pc_q[1:0])) begin
            // Fault is reported through the slot without touching the bus.
            slot_load          = 1'b1;
            slot_load_misalign = 1'b1;
          end else begin
            state_d    = StFetch;
            req_addr_d = pc_q;
          end
        end
      end
      StFetch: begin
        if (redirect_valid) begin
          pc_d       = redirect_pc;
          slot_clear = 1'b1;
          state_d    = iresp_data_ok ? StIdle : StDrain;
        end else if (iresp_data_ok) begin
          slot_load     = 1'b1;
          slot_load_raw = iresp_data;
          pc_d          = pc_q + ADDR_W'(4);
          state_d       = StIdle;
        end
      end
      StDrain: begin
        // Wait out the stale transaction; its data is never used.
        if (redirect_valid) begin
          pc_d       = redirect_pc;
          slot_clear = 1'b1;
        end
        if (iresp_data_ok) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Sequencer state registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      pc_q       <= RESET_PC;
      req_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      req_addr_q <= req_addr_d;
    end
  end

  assign ireq_valid = (state_q == StFetch) || (state_q == StDrain);
  assign ireq_addr  = req_addr_q;

  fetch_ctrl_slot #(
    .ADDR_W (ADDR_W),
    .INSTR_W(INSTR_W)
  ) u_slot (
    .clk_i          (clk),
    .rst_ni         (reset),
    .clear_i        (slot_clear),
    .load_i         (slot_load),
    .load_pc_i      (slot_load_pc),
    .load_raw_i     (slot_load_raw),
    .load_misalign_i(slot_load_misalign),
    .stall_i        (stall),
    .fire_o         (slot_fire),
    .valid_o        (inst_valid),
    .pc_o           (inst_pc),
    .raw_o          (inst_raw),
    .misalign_o     (inst_misalign)
  );

endmodule
